// File: rtl/flight_cmd_if.sv
// Host command channel between the UART command wrapper (master) and the
// flight command sequencer (slave).
interface flight_cmd_if;
  // Handshake: cmd/data are valid while cmd_rdy is high and are consumed in the
  // cycle clr_cmd_rdy is high; resp is valid from the send_resp pulse until the
  // master answers with resp_sent.
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/flight_cmd_cfg.sv
// Command sequencer: decodes host commands into flight setpoints, sequences
// inertial calibration and acknowledges each command. Optional CMD_WDOG_EN adds
// an idle watchdog that performs a silent emergency land.
module flight_cmd_cfg #(
  parameter int FAST_SIM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  flight_cmd_if.slave        host,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic               inertial_cal,
  output logic               motors_off,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    CAL  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] OP_PTCH = 8'h02;
  localparam logic [7:0] OP_ROLL = 8'h03;
  localparam logic [7:0] OP_YAW  = 8'h04;
  localparam logic [7:0] OP_THR  = 8'h05;
  localparam logic [7:0] OP_CAL  = 8'h06;
  localparam logic [7:0] OP_LAND = 8'h07;
  localparam logic [7:0] OP_OFF  = 8'h08;
  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] NAK     = 8'hEE;

  localparam int SPIN_W = (FAST_SIM != 0) ? 9 : 25;

  state_t            state, nxt;
  logic [SPIN_W-1:0] spin_cnt;
  logic              spin_tc;
  logic              consume;
  logic              op_valid;
  logic              clr;
  logic              send_resp_q;
  logic [7:0]        resp_q;
  logic              wd_land;

  assign spin_tc           = &spin_cnt;
  assign consume           = (state == IDLE) && host.cmd_rdy;
  assign op_valid          = (host.cmd >= OP_PTCH) && (host.cmd <= OP_OFF);
  assign host.clr_cmd_rdy  = clr;
  assign host.send_resp    = send_resp_q;
  assign host.resp         = resp_q;
  assign state_dbg         = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    strt_cal = 1'b0;
    case (state)
      IDLE: begin
        if (host.cmd_rdy) begin
          clr = 1'b1;
          nxt = (host.cmd == OP_CAL) ? SPIN : RESP;
        end
      end
      SPIN: begin
        if (spin_tc) begin
          strt_cal = 1'b1;
          nxt      = CAL;
        end
      end
      CAL: begin
        if (cal_done) nxt = RESP;
      end
      RESP: begin
        if (host.resp_sent) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Spin-up timer is cleared when a command is consumed; only 0x06 then
  // enters SPIN, so any stale count is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              spin_cnt <= '0;
    else if (consume)        spin_cnt <= '0;
    else if (state == SPIN)  spin_cnt <= spin_cnt + 1'b1;
  end

`ifdef CMD_WDOG_EN
  localparam int WD_W = (FAST_SIM != 0) ? 12 : 26;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_tc;
  logic            wd_armed;

  assign wd_tc    = &wd_cnt;
  assign wd_armed = (state == IDLE) && !motors_off;
  assign wd_land  = wd_armed && wd_tc && !consume;

  // Saturates at terminal count until the next consumed command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt <= '0;
    else if (consume)            wd_cnt <= '0;
    else if (wd_armed && !wd_tc) wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_land = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_ptch       <= '0;
      d_roll       <= '0;
      d_yaw        <= '0;
      thrst        <= '0;
      motors_off   <= 1'b1;
      inertial_cal <= 1'b0;
      resp_q       <= ACK;
      send_resp_q  <= 1'b0;
    end else begin
      send_resp_q <= (nxt == RESP) && (state != RESP);
      if (consume) begin
        resp_q <= op_valid ? ACK : NAK;
        case (host.cmd)
          OP_PTCH: d_ptch <= host.data;
          OP_ROLL: d_roll <= host.data;
          OP_YAW:  d_yaw  <= host.data;
          OP_THR:  thrst  <= host.data[8:0];
          OP_CAL: begin
            motors_off   <= 1'b0;
            inertial_cal <= 1'b1;
          end
          OP_LAND: begin
            d_ptch <= '0;
            d_roll <= '0;
            d_yaw  <= '0;
            thrst  <= '0;
          end
          OP_OFF:  motors_off <= 1'b1;
          default: ;
        endcase
      end else if (wd_land) begin
        d_ptch <= '0;
        d_roll <= '0;
        d_yaw  <= '0;
        thrst  <= '0;
      end
      if ((state == CAL) && cal_done) begin
        inertial_cal <= 1'b0;
        resp_q       <= ACK;
      end
    end
  end

endmodule

// File: tb/tb_flight_cmd_cfg.sv
// Directed bench for flight_cmd_cfg with a response-byte scoreboard; covers the
// CMD_WDOG_EN watchdog when that macro is defined.
module tb_flight_cmd_cfg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;
  logic        strt_cal, cal_done, inertial_cal, motors_off;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  int resp_sent_cnt = 0;
  logic [7:0] exp_q[$];

  flight_cmd_if bus();

  always #5 clk = ~clk;

  flight_cmd_cfg #(.FAST_SIM(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (bus),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .strt_cal     (strt_cal),
    .cal_done     (cal_done),
    .inertial_cal (inertial_cal),
    .motors_off   (motors_off),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every send_resp pulse must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.send_resp === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_send_resp", 32'd1, 32'd0);
        else                   chk("resp", {24'd0, bus.resp}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // UART wrapper model: answers each send_resp three cycles later.
  initial begin
    logic [7:0] held;
    bus.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_resp === 1'b1) begin
        held = bus.resp;
        repeat (3) @(negedge clk);
        chk("resp_stable", {24'd0, bus.resp}, {24'd0, held});
        bus.resp_sent = 1'b1;
        resp_sent_cnt++;
        @(negedge clk);
        bus.resp_sent = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (state_dbg !== ST_IDLE && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, k < 200}, 32'd1);
  endtask

  // Issues one command; returns at the negedge after the consuming edge.
  task automatic send_cmd(input logic [7:0] op, input logic [15:0] d, input logic [7:0] exp_resp);
    wait_idle();
    bus.cmd = op;
    bus.data = d;
    bus.cmd_rdy = 1'b1;
    #1;
    chk("clr_cmd_rdy", {31'd0, bus.clr_cmd_rdy}, 32'd1);
    exp_q.push_back(exp_resp);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    chk("send_resp_latency", {31'd0, bus.send_resp}, 32'd1);
  endtask

  task automatic issue_cal();
    wait_idle();
    bus.cmd = 8'h06;
    bus.data = 16'h0000;
    bus.cmd_rdy = 1'b1;
    #1;
    chk("cal_clr_cmd_rdy", {31'd0, bus.clr_cmd_rdy}, 32'd1);
    exp_q.push_back(ACK);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    chk("cal_inertial_on", {31'd0, inertial_cal}, 32'd1);
    chk("cal_motors_on", {31'd0, motors_off}, 32'd0);
  endtask

  initial begin
    int cyc;
    int extra;
    int clr_bad;
    int sent_before;
    bit seen;
    bus.cmd_rdy = 1'b0;
    bus.cmd = 8'h00;
    bus.data = 16'h0000;
    cal_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_d_ptch", {16'd0, d_ptch}, 32'd0);
    chk("rst_d_roll", {16'd0, d_roll}, 32'd0);
    chk("rst_d_yaw", {16'd0, d_yaw}, 32'd0);
    chk("rst_thrst", {23'd0, thrst}, 32'd0);
    chk("rst_motors_off", {31'd0, motors_off}, 32'd1);
    chk("rst_inertial_cal", {31'd0, inertial_cal}, 32'd0);
    chk("rst_strt_cal", {31'd0, strt_cal}, 32'd0);
    chk("rst_clr_cmd_rdy", {31'd0, bus.clr_cmd_rdy}, 32'd0);
    chk("rst_send_resp", {31'd0, bus.send_resp}, 32'd0);
    chk("rst_resp", {24'd0, bus.resp}, {24'd0, ACK});

    // Calibration with a stray cal_done during SPIN
    issue_cal();
    cyc = 1;
    seen = 0;
    while (cyc < 2000 && !seen) begin
      @(negedge clk);
      cyc++;
      cal_done = (cyc == 100);
      if (strt_cal === 1'b1) seen = 1;
    end
    cal_done = 1'b0;
    chk("strt_cal_latency", cyc, 32'd512);
    @(negedge clk);
    chk("strt_cal_one_cycle", {31'd0, strt_cal}, 32'd0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (strt_cal === 1'b1) extra++;
    end
    chk("strt_cal_reissue", extra, 32'd0);
    chk("inertial_during_cal", {31'd0, inertial_cal}, 32'd1);
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    chk("cal_inertial_off", {31'd0, inertial_cal}, 32'd0);
    chk("cal_motors_still_on", {31'd0, motors_off}, 32'd0);
    chk("cal_send_resp", {31'd0, bus.send_resp}, 32'd1);

    // Setpoints, including the most-negative boundary
    send_cmd(8'h02, 16'hFF01, ACK);
    chk("d_ptch_neg255", {16'd0, d_ptch}, 32'h0000_FF01);
    send_cmd(8'h03, 16'h00FF, ACK);
    chk("d_roll_00ff", {16'd0, d_roll}, 32'h0000_00FF);
    send_cmd(8'h04, 16'h8000, ACK);
    chk("d_yaw_8000", {16'd0, d_yaw}, 32'h0000_8000);
    send_cmd(8'h05, 16'hFFA0, ACK);
    chk("thrst_1a0", {23'd0, thrst}, 32'h0000_01A0);

    // Emergency land
    send_cmd(8'h07, 16'h1234, ACK);
    chk("land_d_ptch", {16'd0, d_ptch}, 32'd0);
    chk("land_d_roll", {16'd0, d_roll}, 32'd0);
    chk("land_d_yaw", {16'd0, d_yaw}, 32'd0);
    chk("land_thrst", {23'd0, thrst}, 32'd0);

    // Idle behaviour with motors on
    send_cmd(8'h05, 16'h0050, ACK);
    chk("thrst_50", {23'd0, thrst}, 32'h50);
    wait_idle();
`ifdef CMD_WDOG_EN
    repeat (4000) @(negedge clk);
    chk("wdog_not_early", {23'd0, thrst}, 32'h50);
    send_cmd(8'h02, 16'h0001, ACK);
    chk("wdog_d_ptch_set", {16'd0, d_ptch}, 32'h1);
    wait_idle();
    cyc = 0;
    while (thrst !== 9'd0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("wdog_land_cycles", cyc, 32'd4096);
    chk("wdog_d_ptch_zero", {16'd0, d_ptch}, 32'd0);
    repeat (20) @(negedge clk);
    chk("wdog_no_resp_pending", exp_q.size(), 32'd0);
`else
    repeat (5000) @(negedge clk);
    chk("hold_thrst", {23'd0, thrst}, 32'h50);
`endif

    // Motors off, thrust while off, positive boundary, NAK
    send_cmd(8'h08, 16'h0000, ACK);
    chk("motors_off_cmd", {31'd0, motors_off}, 32'd1);
    send_cmd(8'h05, 16'h0010, ACK);
    chk("thrst_while_off", {23'd0, thrst}, 32'h10);
    chk("motors_stay_off", {31'd0, motors_off}, 32'd1);
    send_cmd(8'h04, 16'h7FFF, ACK);
    chk("d_yaw_7fff", {16'd0, d_yaw}, 32'h0000_7FFF);
    send_cmd(8'h1F, 16'hFFFF, NAK);
    chk("nak_d_yaw", {16'd0, d_yaw}, 32'h0000_7FFF);
    chk("nak_thrst", {23'd0, thrst}, 32'h10);
    chk("nak_motors_off", {31'd0, motors_off}, 32'd1);

    // Command held during SPIN/CAL is serviced only after the calibration ACK
    issue_cal();
    bus.cmd = 8'h03;
    bus.data = 16'h0005;
    bus.cmd_rdy = 1'b1;
    clr_bad = 0;
    cyc = 0;
    while (cyc < 2000 && strt_cal !== 1'b1) begin
      @(negedge clk);
      cyc++;
      if (bus.clr_cmd_rdy === 1'b1) clr_bad++;
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy === 1'b1) clr_bad++;
    end
    sent_before = resp_sent_cnt;
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    cyc = 0;
    while (cyc < 100 && bus.clr_cmd_rdy !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_cmd_timeout", {31'd0, cyc < 100}, 32'd1);
    chk("held_after_ack", resp_sent_cnt, sent_before + 1);
    chk("held_no_early_clr", clr_bad, 32'd0);
    exp_q.push_back(ACK);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    chk("held_d_roll", {16'd0, d_roll}, 32'h5);

    // Reset in the middle of CAL
    issue_cal();
    cyc = 0;
    while (cyc < 2000 && strt_cal !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    chk("pre_rst_inertial", {31'd0, inertial_cal}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_cal_inertial", {31'd0, inertial_cal}, 32'd0);
    chk("rst_cal_motors_off", {31'd0, motors_off}, 32'd1);
    chk("rst_cal_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_cal_d_roll", {16'd0, d_roll}, 32'd0);

    // Post-reset command still works
    send_cmd(8'h02, 16'h8000, ACK);
    chk("post_rst_d_ptch", {16'd0, d_ptch}, 32'h0000_8000);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flight_cmd_cfg.md
Name: flight_cmd_cfg

Overview:
Command sequencer between the UART command wrapper and the flight datapath (inertial integrator, flight controller, ESC drivers). Decodes host command/data pairs into registered pitch/roll/yaw/thrust setpoints. Sequences inertial calibration: motor spin-up wait, calibration start, calibration-done handshake. Issues one response byte per executed command.

Parameters:
FAST_SIM, 1, 1 selects a short spin-up timer (2^9 clk) and short watchdog (2^12 clk); 0 selects 2^25 clk spin-up and 2^26 clk watchdog.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_rdy  in  1  command/data pair valid from UART wrapper
cmd  in  8  command opcode
data  in  16  command data
clr_cmd_rdy  out  1  one-cycle pulse, command consumed
resp  out  8  response byte to UART wrapper
send_resp  out  1  one-cycle pulse, transmit resp
resp_sent  in  1  UART wrapper finished transmitting resp
d_ptch  out  16  signed desired pitch
d_roll  out  16  signed desired roll
d_yaw  out  16  signed desired yaw
thrst  out  9  unsigned desired thrust
strt_cal  out  1  one-cycle pulse, start inertial calibration
cal_done  in  1  one-cycle pulse, calibration finished
inertial_cal  out  1  high during spin-up and calibration; flight controller drives calibration motor speed 0x290
motors_off  out  1  forces all ESC speeds to zero

Behaviour:
- Reset: d_ptch=d_roll=d_yaw=0, thrst=0, motors_off=1, inertial_cal=0, strt_cal=0, clr_cmd_rdy=0, send_resp=0, resp=0xA5, state IDLE.
- Opcodes: 0x02 pitch, 0x03 roll, 0x04 yaw, 0x05 thrust (data[8:0]), 0x06 calibrate, 0x07 emergency land, 0x08 motors off. Data bits outside the target width are ignored.
- States: IDLE, SPIN, CAL, RESP.
- IDLE + cmd_rdy: clr_cmd_rdy is asserted combinationally in that cycle.
  - Setpoint opcodes: target register loads on the same edge; goes to RESP.
  - 0x07: all three setpoints and thrst go to 0; goes to RESP.
  - 0x08: motors_off goes to 1; goes to RESP.
  - 0x06: clears motors_off, sets inertial_cal, clears the spin timer, goes to SPIN.
  - Any other opcode: resp=0xEE (NAK), registers unchanged, goes to RESP.
  - All other executed commands set resp=0xA5.
- SPIN: spin timer counts each clk. When the timer reaches terminal count, strt_cal pulses for exactly one cycle and the state goes to CAL.
- CAL: waits for cal_done. On cal_done, inertial_cal goes to 0, resp=0xA5, and the state goes to RESP.
- RESP: send_resp pulses one cycle on entry; the block then holds until resp_sent and returns to IDLE.
- Latency: setpoint valid at the edge after cmd_rdy is seen; send_resp on the following cycle. resp is stable from send_resp until resp_sent.
- cmd_rdy outside IDLE: not consumed, clr_cmd_rdy stays 0, and the command is serviced on return to IDLE.
- Setpoints loaded with data=0x8000 (most negative) and 0x7FFF are passed through unmodified.
- cal_done arriving in SPIN or IDLE is ignored. strt_cal is never re-issued without a new 0x06.
- Reset mid-calibration: inertial_cal drops immediately, motors_off=1, state IDLE.
- motors_off clears only on calibration. A thrust command while motors_off=1 updates thrst but motors stay off.

Optional Feature:
Macro CMD_WDOG_EN. With the macro defined:
- A watchdog counter increments every clk while motors_off=0 and the state is IDLE.
- The counter clears on any consumed command.
- At terminal count it performs an internal emergency land: setpoints and thrst go to 0, with no response sent. The counter then saturates until the next command.
Without the macro, no counter exists and setpoints hold indefinitely.

Test Plan:
- Reset, then 0x06 with FAST_SIM=1 -> inertial_cal=1 the cycle after clr_cmd_rdy; strt_cal pulses once 512 clks later; cal_done -> inertial_cal=0, motors_off=0, send_resp with resp=0xA5.
- 0x02 data=0xFF01 -> d_ptch=-255 one edge after cmd_rdy; send_resp next cycle with resp 0xA5. Repeat roll=0x00FF and yaw=0x8000 -> values exact.
- 0x05 data=0xFFA0 -> thrst=0x1A0; then 0x07 -> d_ptch=d_roll=d_yaw=0, thrst=0, resp 0xA5.
- 0x08 -> motors_off=1, resp 0xA5. Then 0x05 data=0x10 -> thrst=0x10 with motors_off still 1. Opcode 0x1F -> resp 0xEE with registers unchanged.
- cmd_rdy held during SPIN with 0x03 data=5 -> no clr_cmd_rdy until after the calibration ACK's resp_sent; then d_roll=5. Assert rst_n=0 during CAL -> inertial_cal=0, motors_off=1 immediately.
- CMD_WDOG_EN, FAST_SIM=1, motors on, thrst=0x50 -> after 4096 idle clks thrst=0 with no send_resp; a command at clk 4000 restarts the count.
